// File: rtl/multih_lock_pkg.sv
// Shared types and helpers for the multi-h carrier-loop lock detector and
// symbol-slip controller.
package multih_lock_pkg;

    typedef enum logic [1:0] {
        LOCKED,
        UNLOCKED,
        SLIP_PEND,
        SLIP_WAIT
    } lock_state_e;

    // Magnitude of a width-bit signed sample. The most negative code is folded
    // onto the largest positive magnitude so the result always fits width-1 bits.
    function automatic logic [31:0] satAbs(input int value, input int width);
        int maxMag;
        int mag;
        maxMag = (1 << (width - 1)) - 1;
        mag    = (value < 0) ? -value : value;
        satAbs = 32'((mag > maxMag) ? maxMag : mag);
    endfunction

    // Limits the requested averaging exponent to what the accumulator was sized for.
    function automatic logic [2:0] clampLog2(input logic [2:0] req, input int maxLog2);
        int lim;
        lim       = (maxLog2 > 7) ? 7 : maxLog2;
        clampLog2 = (int'(req) > lim) ? 3'(lim) : req;
    endfunction

endpackage

// File: rtl/multih_abs_err_avg.sv
// Windowed average of |phase error| over 2^N qualified samples, where N is
// captured when the first sample of each window arrives.
module multih_abs_err_avg
    import multih_lock_pkg::*;
#(
    parameter int ERR_W        = 8,
    parameter int AVG_LOG2_MAX = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             sample_i,
    input  logic [ERR_W-1:0] error_i,
    input  logic [2:0]       avgLog2_i,
    output logic [ERR_W-2:0] avgAbsError_o,
    output logic             avgEn_o
);

    localparam int ABS_W  = ERR_W - 1;
    localparam int ACC_W  = ABS_W + AVG_LOG2_MAX;
    localparam int SCNT_W = AVG_LOG2_MAX + 1;

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [SCNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]        winLog2_q, winLog2_d;
    logic [ABS_W-1:0]  avg_q, avg_d;
    logic              avgEn_q, avgEn_d;

    logic [ABS_W-1:0]  absVal;
    logic [2:0]        curLog2;
    logic [SCNT_W-1:0] winLen;
    logic [ACC_W-1:0]  accSum;

    // Accumulate the saturated magnitude; close the window on its 2^N-th sample.
    always_comb begin
        absVal    = ABS_W'(satAbs(int'($signed(error_i)), ERR_W));
        curLog2   = (cnt_q == '0) ? clampLog2(avgLog2_i, AVG_LOG2_MAX) : winLog2_q;
        winLen    = SCNT_W'(1) << curLog2;
        accSum    = acc_q + ACC_W'(absVal);

        acc_d     = acc_q;
        cnt_d     = cnt_q;
        winLog2_d = winLog2_q;
        avg_d     = avg_q;
        avgEn_d   = 1'b0;

        if (clear_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (sample_i) begin
            winLog2_d = curLog2;
            if (cnt_q + SCNT_W'(1) == winLen) begin
                avg_d   = ABS_W'(accSum >> curLog2);
                avgEn_d = 1'b1;
                acc_d   = '0;
                cnt_d   = '0;
            end else begin
                acc_d = accSum;
                cnt_d = cnt_q + SCNT_W'(1);
            end
        end
    end

    // Window state and the published average.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            winLog2_q <= '0;
            avg_q     <= '0;
            avgEn_q   <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            winLog2_q <= winLog2_d;
            avg_q     <= avg_d;
            avgEn_q   <= avgEn_d;
        end
    end

    assign avgAbsError_o = avg_q;
    assign avgEn_o       = avgEn_q;

endmodule

// File: rtl/multih_lock_slip_ctrl.sv
// Lock detector and symbol-slip controller for the multi-h carrier loop:
// leaky good/bad counters on windowed |error| averages drive a lock/slip FSM
// that drops exactly one symbol enable per slip.
module multih_lock_slip_ctrl
    import multih_lock_pkg::*;
#(
    parameter int ERR_W        = 8,
    parameter int CNT_W        = 16,
    parameter int AVG_LOG2_MAX = 7,
    parameter int SLIP_W       = 4,
    parameter int HOLDOFF      = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              errEn,
    input  logic              errValid,
    input  logic [ERR_W-1:0]  error,
    input  logic [2:0]        avgLog2,
    input  logic [ERR_W-2:0]  threshold,
    input  logic [CNT_W-1:0]  lockCount,
    input  logic [CNT_W-1:0]  unlockCount,
    input  logic [SLIP_W-1:0] maxSlips,
    input  logic              clearStats,
    input  logic              symEnIn,
    output logic              symEnOut,
    output logic              demodLock,
    output logic              slipActive,
    output logic [SLIP_W-1:0] slipCount,
    output logic              slipExhausted,
    output logic [ERR_W-2:0]  avgAbsError,
    output logic              avgEn
);

    localparam int HOLD_W = 8;

    lock_state_e       state_q, state_d;
    logic [CNT_W-1:0]  goodCnt_q, goodCnt_d;
    logic [CNT_W-1:0]  badCnt_q, badCnt_d;
    logic [SLIP_W-1:0] slipCount_q, slipCount_d;
    logic              slipExh_q, slipExh_d;
    logic [HOLD_W-1:0] holdCnt_q, holdCnt_d;
    logic              symEnOut_q, symEnOut_d;

    logic              slipFire;
    logic              avgLive;
    logic              classify;
    logic              isBad;
    logic [CNT_W-1:0]  lockTarget;
    logic [CNT_W-1:0]  unlockTarget;
    logic              lockEv;
    logic              unlockEv;

    multih_abs_err_avg #(
        .ERR_W       (ERR_W),
        .AVG_LOG2_MAX(AVG_LOG2_MAX)
    ) uAvg (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (clearStats | slipFire),
        .sample_i     (errEn & errValid),
        .error_i      (error),
        .avgLog2_i    (avgLog2),
        .avgAbsError_o(avgAbsError),
        .avgEn_o      (avgEn)
    );

    // Classify each fresh average and detect lock/unlock events; clearStats masks the average.
    always_comb begin
        slipFire     = (state_q == SLIP_PEND) && symEnIn;
        avgLive      = avgEn && !clearStats;
        classify     = avgLive && ((state_q == LOCKED) || (state_q == UNLOCKED));
        isBad        = avgAbsError > threshold;
        lockTarget   = (lockCount == '0) ? CNT_W'(1) : lockCount;
        unlockTarget = (unlockCount == '0) ? CNT_W'(1) : unlockCount;
        lockEv       = classify && !isBad && (goodCnt_q == lockTarget - CNT_W'(1));
        unlockEv     = classify && isBad && (badCnt_q == unlockTarget - CNT_W'(1));
    end

    // Leaky good/bad counters: each average bumps one and bleeds the other.
    always_comb begin
        goodCnt_d = goodCnt_q;
        badCnt_d  = badCnt_q;
        if (clearStats || slipFire || lockEv || unlockEv) begin
            goodCnt_d = '0;
            badCnt_d  = '0;
        end else if (classify) begin
            if (isBad) begin
                badCnt_d  = (badCnt_q == '1) ? badCnt_q : badCnt_q + CNT_W'(1);
                goodCnt_d = (goodCnt_q == '0) ? goodCnt_q : goodCnt_q - CNT_W'(1);
            end else begin
                goodCnt_d = (goodCnt_q == '1) ? goodCnt_q : goodCnt_q + CNT_W'(1);
                badCnt_d  = (badCnt_q == '0) ? badCnt_q : badCnt_q - CNT_W'(1);
            end
        end
    end

    // Lock/slip state machine plus the gated symbol enable.
    always_comb begin
        state_d     = state_q;
        slipCount_d = slipCount_q;
        slipExh_d   = slipExh_q;
        holdCnt_d   = holdCnt_q;
        symEnOut_d  = symEnIn && !slipFire;

        case (state_q)
            LOCKED: begin
                if (unlockEv) begin
                    state_d = UNLOCKED;
                end
            end
            UNLOCKED: begin
                if (lockEv) begin
                    state_d     = LOCKED;
                    slipCount_d = '0;
                    slipExh_d   = 1'b0;
                end else if (unlockEv) begin
                    if (slipCount_q < maxSlips) begin
                        state_d     = SLIP_PEND;
                        slipCount_d = slipCount_q + SLIP_W'(1);
                    end else begin
                        slipExh_d = 1'b1;
                    end
                end
            end
            SLIP_PEND: begin
                if (slipFire) begin
                    holdCnt_d = '0;
                    state_d   = (HOLDOFF == 0) ? UNLOCKED : SLIP_WAIT;
                end
            end
            SLIP_WAIT: begin
                if (avgLive) begin
                    if (holdCnt_q == HOLD_W'(HOLDOFF - 1)) begin
                        state_d = UNLOCKED;
                    end else begin
                        holdCnt_d = holdCnt_q + HOLD_W'(1);
                    end
                end
            end
            default: begin
                state_d = LOCKED;
            end
        endcase

        if (clearStats) begin
            slipCount_d = '0;
            slipExh_d   = 1'b0;
        end
    end

    // State, counters and the registered symbol enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= LOCKED;
            goodCnt_q   <= '0;
            badCnt_q    <= '0;
            slipCount_q <= '0;
            slipExh_q   <= 1'b0;
            holdCnt_q   <= '0;
            symEnOut_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            goodCnt_q   <= goodCnt_d;
            badCnt_q    <= badCnt_d;
            slipCount_q <= slipCount_d;
            slipExh_q   <= slipExh_d;
            holdCnt_q   <= holdCnt_d;
            symEnOut_q  <= symEnOut_d;
        end
    end

    assign symEnOut      = symEnOut_q;
    assign demodLock     = (state_q == LOCKED);
    assign slipActive    = (state_q == SLIP_PEND) || (state_q == SLIP_WAIT);
    assign slipCount     = slipCount_q;
    assign slipExhausted = slipExh_q;

endmodule

// File: tb/tb_multih_lock_slip_ctrl.sv
// Self-checking bench for multih_lock_slip_ctrl: averaging vectors, directed
// lock/slip sequences, then randomized traffic against a behavioural model.
module tb_multih_lock_slip_ctrl;

    localparam int ERR_W   = 8;
    localparam int CNT_W   = 16;
    localparam int AVG_MAX = 7;
    localparam int SLIP_W  = 4;
    localparam int HOLDOFF = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              errEn = 1'b0;
    logic              errValid = 1'b0;
    logic [ERR_W-1:0]  error = '0;
    logic [2:0]        avgLog2 = '0;
    logic [ERR_W-2:0]  threshold = '0;
    logic [CNT_W-1:0]  lockCount = '0;
    logic [CNT_W-1:0]  unlockCount = '0;
    logic [SLIP_W-1:0] maxSlips = '0;
    logic              clearStats = 1'b0;
    logic              symEnIn = 1'b0;
    logic              symEnOut;
    logic              demodLock;
    logic              slipActive;
    logic [SLIP_W-1:0] slipCount;
    logic              slipExhausted;
    logic [ERR_W-2:0]  avgAbsError;
    logic              avgEn;

    int checks = 0;
    int errors = 0;

    multih_lock_slip_ctrl #(
        .ERR_W(ERR_W), .CNT_W(CNT_W), .AVG_LOG2_MAX(AVG_MAX), .SLIP_W(SLIP_W), .HOLDOFF(HOLDOFF)
    ) dut (
        .clk(clk), .reset(reset), .errEn(errEn), .errValid(errValid), .error(error),
        .avgLog2(avgLog2), .threshold(threshold), .lockCount(lockCount),
        .unlockCount(unlockCount), .maxSlips(maxSlips), .clearStats(clearStats),
        .symEnIn(symEnIn), .symEnOut(symEnOut), .demodLock(demodLock),
        .slipActive(slipActive), .slipCount(slipCount), .slipExhausted(slipExhausted),
        .avgAbsError(avgAbsError), .avgEn(avgEn)
    );

    always #5 clk = ~clk;

    typedef struct {
        int log2;
        int e0;
        int e1;
        int e2;
        int e3;
        int expAvg;
    } avgVec_t;

    avgVec_t vecs[6];

    // Behavioural model: window kept as a queue of magnitudes, lock/slip as flags.
    int mq[$];
    int mWinN, mHoldLeft, mGood, mBad, mSlips, mAvg;
    bit mLocked, mPend, mWait, mExh, mAvgEn, mSymOut;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit en, input bit valid, input int err, input bit sym);
        errEn    = en;
        errValid = valid;
        error    = ERR_W'(err);
        symEnIn  = sym;
        tick();
    endtask

    // One qualified sample; with avgLog2=0 this is one full average.
    task automatic sendAvg(input int err);
        applyStimulus(1'b1, 1'b1, err, 1'b0);
        errEn = 1'b0;
    endtask

    task automatic modelReset();
        mq.delete();
        mWinN = 0; mHoldLeft = 0; mGood = 0; mBad = 0; mSlips = 0; mAvg = 0;
        mLocked = 1'b1; mPend = 1'b0; mWait = 1'b0; mExh = 1'b0; mAvgEn = 1'b0; mSymOut = 1'b0;
    endtask

    task automatic doReset();
        errEn = 1'b0; errValid = 1'b0; symEnIn = 1'b0; clearStats = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        modelReset();
    endtask

    task automatic setConfig(input int thr, input int lockC, input int unlockC, input int slips);
        threshold   = (ERR_W-1)'(thr);
        lockCount   = CNT_W'(lockC);
        unlockCount = CNT_W'(unlockC);
        maxSlips    = SLIP_W'(slips);
    endtask

    function automatic int pickErr(input avgVec_t v, input int s);
        case (s)
            0: return v.e0;
            1: return v.e1;
            2: return v.e2;
            default: return v.e3;
        endcase
    endfunction

    // Advance the model across one clock edge using the inputs currently driven.
    task automatic modelStep();
        bit fire, useAvg, isBad, lockHit, unlockHit;
        int lockT, unlockT, e, mag;
        fire      = mPend && symEnIn;
        useAvg    = mAvgEn && !clearStats && !mPend && !mWait;
        isBad     = mAvg > int'(threshold);
        lockT     = (lockCount == 0) ? 1 : int'(lockCount);
        unlockT   = (unlockCount == 0) ? 1 : int'(unlockCount);
        lockHit   = useAvg && !isBad && (mGood == lockT - 1);
        unlockHit = useAvg && isBad && (mBad == unlockT - 1);

        if (mWait) begin
            if (mAvgEn && !clearStats) begin
                mHoldLeft--;
                if (mHoldLeft == 0) mWait = 1'b0;
            end
        end else if (fire) begin
            mPend     = 1'b0;
            mHoldLeft = HOLDOFF;
            mWait     = (HOLDOFF > 0);
        end else if (mLocked) begin
            if (unlockHit) mLocked = 1'b0;
        end else if (!mPend) begin
            if (lockHit) begin
                mLocked = 1'b1; mSlips = 0; mExh = 1'b0;
            end else if (unlockHit) begin
                if (mSlips < int'(maxSlips)) begin
                    mPend = 1'b1;
                    mSlips++;
                end else begin
                    mExh = 1'b1;
                end
            end
        end

        if (clearStats || fire || lockHit || unlockHit) begin
            mGood = 0; mBad = 0;
        end else if (useAvg) begin
            if (isBad) begin
                mBad  = (mBad < 65535) ? mBad + 1 : mBad;
                mGood = (mGood > 0) ? mGood - 1 : 0;
            end else begin
                mGood = (mGood < 65535) ? mGood + 1 : mGood;
                mBad  = (mBad > 0) ? mBad - 1 : 0;
            end
        end
        if (clearStats) begin
            mSlips = 0; mExh = 1'b0;
        end

        mAvgEn = 1'b0;
        if (clearStats || fire) begin
            mq.delete();
        end else if (errEn && errValid) begin
            if (mq.size() == 0) mWinN = (int'(avgLog2) > AVG_MAX) ? AVG_MAX : int'(avgLog2);
            e   = int'($signed(error));
            mag = (e < 0) ? -e : e;
            if (mag > 127) mag = 127;
            mq.push_back(mag);
            if (mq.size() == (1 << mWinN)) begin
                mAvg   = mq.sum() >> mWinN;
                mAvgEn = 1'b1;
                mq.delete();
            end
        end
        mSymOut = symEnIn && !fire;
    endtask

    initial begin
        vecs[0] = '{2, 10, -20, 30, -41, 25};
        vecs[1] = '{2, -128, -128, -128, -128, 127};
        vecs[2] = '{1, -128, 0, 0, 0, 63};
        vecs[3] = '{0, -5, 0, 0, 0, 5};
        vecs[4] = '{2, 1, 2, 3, -1, 1};
        vecs[5] = '{1, 127, -127, 0, 0, 127};

        // Reset values.
        doReset();
        checkOutput("reset demodLock", demodLock, 1);
        checkOutput("reset symEnOut", symEnOut, 0);
        checkOutput("reset slipActive", slipActive, 0);
        checkOutput("reset slipCount", slipCount, 0);
        checkOutput("reset slipExhausted", slipExhausted, 0);
        checkOutput("reset avgAbsError", avgAbsError, 0);
        checkOutput("reset avgEn", avgEn, 0);

        // Averaging vectors; a threshold of 127 keeps every average good.
        setConfig(127, 4, 3, 2);
        for (int v = 0; v < 6; v++) begin
            int n;
            avgLog2 = 3'(vecs[v].log2);
            n = 1 << vecs[v].log2;
            for (int s = 0; s < n; s++) begin
                applyStimulus(1'b1, 1'b1, pickErr(vecs[v], s), 1'b0);
                if (s < n - 1) checkOutput($sformatf("vec%0d avgEn early", v), avgEn, 0);
            end
            errEn = 1'b0;
            checkOutput($sformatf("vec%0d avgEn", v), avgEn, 1);
            checkOutput($sformatf("vec%0d avgAbsError", v), avgAbsError, vecs[v].expAvg);
            tick();
            checkOutput($sformatf("vec%0d avgEn width", v), avgEn, 0);
        end
        checkOutput("vectors demodLock", demodLock, 1);

        // Three bad averages unlock; demodLock falls the cycle after the third avgEn.
        doReset();
        setConfig(20, 4, 3, 2);
        avgLog2 = 3'd0;
        sendAvg(40); sendAvg(40); sendAvg(40);
        checkOutput("unlock lock at 3rd avgEn", demodLock, 1);
        tick();
        checkOutput("unlock demodLock", demodLock, 0);

        // A boundary-good average between bads delays unlock by two averages.
        doReset();
        sendAvg(40); sendAvg(40); sendAvg(-20); sendAvg(40);
        tick();
        checkOutput("delayed unlock held", demodLock, 1);
        sendAvg(40);
        checkOutput("delayed unlock 5th avgEn", demodLock, 1);
        tick();
        checkOutput("delayed unlock demodLock", demodLock, 0);

        // Slip: one enable dropped, holdoff of two discarded averages.
        sendAvg(40); sendAvg(40); sendAvg(40);
        applyStimulus(1'b0, 1'b1, 0, 1'b1);
        checkOutput("slip1 pass before", symEnOut, 1);
        checkOutput("slip1 slipActive", slipActive, 1);
        checkOutput("slip1 slipCount", slipCount, 1);
        applyStimulus(1'b0, 1'b1, 0, 1'b1);
        checkOutput("slip1 dropped", symEnOut, 0);
        applyStimulus(1'b0, 1'b1, 0, 1'b1);
        checkOutput("slip1 next passes", symEnOut, 1);
        applyStimulus(1'b0, 1'b1, 0, 1'b1);
        checkOutput("slip1 third passes", symEnOut, 1);
        applyStimulus(1'b0, 1'b1, 0, 1'b0);
        checkOutput("slip1 idle", symEnOut, 0);
        sendAvg(40);
        checkOutput("holdoff 1 slipActive", slipActive, 1);
        sendAvg(40);
        checkOutput("holdoff 2 slipActive", slipActive, 1);
        tick();
        checkOutput("holdoff done slipActive", slipActive, 0);
        checkOutput("holdoff done demodLock", demodLock, 0);
        sendAvg(40); sendAvg(40);
        tick();
        checkOutput("discards not counted", slipActive, 0);
        sendAvg(40);
        tick();
        checkOutput("slip2 slipActive", slipActive, 1);
        checkOutput("slip2 slipCount", slipCount, 2);
        applyStimulus(1'b0, 1'b1, 0, 1'b1);
        checkOutput("slip2 dropped", symEnOut, 0);
        symEnIn = 1'b0;
        sendAvg(40); sendAvg(40);
        tick();
        checkOutput("slip2 holdoff done", slipActive, 0);
        sendAvg(40); sendAvg(40); sendAvg(40);
        tick();
        checkOutput("budget slipExhausted", slipExhausted, 1);
        checkOutput("budget slipActive", slipActive, 0);
        checkOutput("budget slipCount", slipCount, 2);
        applyStimulus(1'b0, 1'b1, 0, 1'b1);
        checkOutput("budget no drop", symEnOut, 1);
        symEnIn = 1'b0;
        sendAvg(5); sendAvg(5); sendAvg(5);
        tick();
        checkOutput("relock after 3 good", demodLock, 0);
        sendAvg(5);
        tick();
        checkOutput("relock demodLock", demodLock, 1);
        checkOutput("relock slipCount", slipCount, 0);
        checkOutput("relock slipExhausted", slipExhausted, 0);

        // clearStats coincident with avgEn suppresses the event and zeroes counters.
        doReset();
        sendAvg(40); sendAvg(40); sendAvg(40);
        clearStats = 1'b1;
        tick();
        clearStats = 1'b0;
        checkOutput("clear blocks unlock", demodLock, 1);
        sendAvg(40); sendAvg(40);
        tick();
        checkOutput("clear zeroed counters", demodLock, 1);
        sendAvg(40);
        tick();
        checkOutput("clear then unlock", demodLock, 0);

        // avgLog2 change mid-window: the old window length completes first.
        doReset();
        setConfig(127, 4, 3, 2);
        avgLog2 = 3'd2;
        sendAvg(4); sendAvg(8);
        avgLog2 = 3'd0;
        sendAvg(12);
        checkOutput("midwin no early avgEn", avgEn, 0);
        sendAvg(16);
        checkOutput("midwin avgEn", avgEn, 1);
        checkOutput("midwin avgAbsError", avgAbsError, 10);
        sendAvg(50);
        checkOutput("new window avgEn", avgEn, 1);
        checkOutput("new window avgAbsError", avgAbsError, 50);
        avgLog2 = 3'd1;
        applyStimulus(1'b1, 1'b1, 10, 1'b0);
        applyStimulus(1'b1, 1'b0, 100, 1'b0);
        applyStimulus(1'b0, 1'b1, 100, 1'b0);
        checkOutput("unqualified ignored", avgEn, 0);
        sendAvg(-20);
        checkOutput("qualified avgAbsError", avgAbsError, 15);

        // Reset asserted while a slip is pending aborts it without dropping an enable.
        doReset();
        setConfig(20, 4, 3, 2);
        avgLog2 = 3'd0;
        sendAvg(40); sendAvg(40); sendAvg(40);
        tick();
        sendAvg(40); sendAvg(40); sendAvg(40);
        tick();
        checkOutput("pend slipActive", slipActive, 1);
        symEnIn = 1'b1;
        #2 reset = 1'b1;
        #1;
        checkOutput("midslip reset symEnOut", symEnOut, 0);
        checkOutput("midslip reset demodLock", demodLock, 1);
        checkOutput("midslip reset slipActive", slipActive, 0);
        checkOutput("midslip reset slipCount", slipCount, 0);
        checkOutput("midslip reset avgAbsError", avgAbsError, 0);
        checkOutput("midslip reset avgEn", avgEn, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        tick();
        checkOutput("midslip enable not dropped", symEnOut, 1);
        symEnIn = 1'b0;

        // Randomized traffic against the model, alternating quiet and noisy phases.
        doReset();
        for (int cyc = 0; cyc < 3000 && errors < 30; cyc++) begin
            bit noisy;
            if (cyc % 250 == 0) begin
                noisy = ((cyc / 250) % 2) == 0;
                setConfig(30, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            end
            errEn      = ($urandom_range(0, 3) != 0);
            errValid   = ($urandom_range(0, 7) != 0);
            error      = noisy ? ERR_W'($urandom_range(0, 255))
                               : ERR_W'(int'($urandom_range(0, 40)) - 20);
            symEnIn    = ($urandom_range(0, 2) == 0);
            clearStats = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 49) == 0) avgLog2 = 3'($urandom_range(0, 3));
            modelStep();
            tick();
            checkOutput($sformatf("rand%0d demodLock", cyc), demodLock, mLocked);
            checkOutput($sformatf("rand%0d slipActive", cyc), slipActive, mPend || mWait);
            checkOutput($sformatf("rand%0d slipCount", cyc), slipCount, mSlips);
            checkOutput($sformatf("rand%0d slipExhausted", cyc), slipExhausted, mExh);
            checkOutput($sformatf("rand%0d symEnOut", cyc), symEnOut, mSymOut);
            checkOutput($sformatf("rand%0d avgEn", cyc), avgEn, mAvgEn);
            checkOutput($sformatf("rand%0d avgAbsError", cyc), avgAbsError, mAvg);
        end
        clearStats = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #2000000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
